gfau_param: RTL and testbench
=============================

Name: gfau_param

Overview:
- Parametrised GF(p) arithmetic unit. Computes modular add, subtract, Montgomery multiply and divide on WIDTH-bit operands.
- Uses a single start/done handshake and one shared result register.
- Sits between the point-arithmetic controller and the operand register file. It is the next-generation replacement for the fixed 32-bit field unit.

Parameters:
- WIDTH, 32, operand/prime bit width (>=4).
- CNT_W, $clog2(4*WIDTH+4), width of the iteration/timeout counter.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous active-high reset.
- start  in  1  request; sampled only in IDLE.
- op_sel  in  2  0 add, 1 sub, 2 Montgomery mult, 3 div.
- in_0  in  WIDTH  operand a (must be < prime).
- in_1  in  WIDTH  operand b (must be < prime).
- prime  in  WIDTH  odd modulus p, 3 <= p < 2^WIDTH.
- busy  out  1  high from the cycle after accept until done.
- done  out  1  one-cycle pulse; result/err valid.
- result  out  WIDTH  last result, held until next accept.
- err  out  1  valid with done; 1 = invalid operation.

Behaviour:
- Reset (async, i_rst=1): state IDLE; busy=0, done=0, err=0, result=0; all internal registers cleared. Reset mid-operation aborts with no done pulse.
- Accept: start=1 in IDLE latches op_sel, in_0, in_1, prime. Inputs may change afterwards. start while busy or during the done cycle is ignored, with no queueing.
- States: IDLE, ADDSUB, MULT, MFIX, DIV, FIN.
- Accept at cycle N.
- add: s = a+b, computed in WIDTH+1 bits. If s >= p, use s-p. done at N+2.
- sub: if a >= b, use a-b, else a-b+p (WIDTH+1 bits). done at N+2.
- mult: m computed in WIDTH+2 bits, m=0 at start.
  - WIDTH iterations, one per cycle, i=0..WIDTH-1: t = m + (a[i] ? b : 0); if t is odd, t = t+p; m = t>>1.
  - MFIX: if m >= p, m = m-p (use >=, not >).
  - Result = a*b*2^-WIDTH mod p. done at N+WIDTH+3.
- div: result = a * b^-1 mod p.
  - Init: u=b, v=p, x1=a, x2=0.
  - One step per cycle, first matching rule applies:
    - u even: u>>=1; x1 = half(x1).
    - v even: v>>=1; x2 = half(x2).
    - u >= v: u -= v; x1 = x1 - x2 mod p.
    - otherwise: v -= u; x2 = x2 - x1 mod p.
  - half(x) = x even ? x>>1 : (x+p)>>1, computed in WIDTH+1 bits.
  - Terminate when u==1 (result x1) or v==1 (result x2). Termination is checked before each step, so b==1 finishes immediately.
  - Latency is variable, at most 4*WIDTH+4 cycles.
- Div by zero: b==0 skips stepping, sets err=1 and result=0, done at N+2.
- Timeout: if the step counter reaches 4*WIDTH+4, the unit stops and reports err=1, result=0 (guards a non-prime p).
- FIN: done=1 and busy=0 for one cycle, then IDLE. result/err hold until the next accept.
- A start pulse arriving on the done cycle is not accepted; the controller re-issues it next cycle.

Optional Feature:
- GFAU_OPERAND_CHECK_EN defined: at accept, if in_0 >= prime or in_1 >= prime, the unit skips the operation, sets err=1, result=0, and pulses done at N+2.
- Not defined: operands are not checked, and results for out-of-range operands are undefined but the latency rules still hold.

Decomposition:
- Shared package gfau_pkg holds:
  - op encoding constants OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3;
  - state enum;
  - timeout constant expression 4*WIDTH+4.
- One natural sub-module: gfau_half_mod. It is the combinational (x even ? x : x+p)>>1, instantiated twice in the div datapath.

Test Plan (WIDTH=8, prime=251):
- add 200+100 -> result=49, err=0, done at N+2. Also 1+250 -> 0.
- sub 10-20 -> 241. Also 20-20 -> 0.
- mult a=5, b=7 -> 7 (35*2^-8 mod 251), done exactly at N+11. Also a=250, b=250 exercises MFIX.
- div 10/5 -> 2; div 1/2 -> 126; div x/1 -> x. Check err=0 and done within 36 cycles.
- div 7/0 -> err=1, result=0, done at N+2. A start asserted while busy is ignored, and the prior result holds until the next accept.
- Reset mid-mult (cycle N+4) -> all outputs 0 immediately, no done pulse. A fresh add after reset is correct.
- Feature enabled: in_0=251 -> err=1 at N+2. Feature disabled: the same stimulus still gives done at N+2.

Source files
------------

// File: rtl/gfau_pkg.sv
//==============================================================================
// Module : gfau_pkg
// Brief  : Shared op codes, FSM states and timeout limit for the GF(p) unit.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package gfau_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDSUB = 3'd1,
    S_MULT   = 3'd2,
    S_MFIX   = 3'd3,
    S_DIV    = 3'd4,
    S_FIN    = 3'd5
  } state_t;

  function automatic int timeout_limit(input int width);
    return 4 * width + 4;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gfau_half_mod.sv
//==============================================================================
// Module : gfau_half_mod
// Brief  : Modular halving, y = (x even ? x : x + p) >> 1, for odd p and x < p.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module gfau_half_mod
  import gfau_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH:0] w_sum;

  assign w_sum = {1'b0, x} + (x[0] ? {1'b0, p} : {(WIDTH+1){1'b0}});
  assign y     = WIDTH'(w_sum >> 1);

endmodule

`default_nettype wire

// File: rtl/gfau_param.sv
//==============================================================================
// Module : gfau_param
// Brief  : Parametrised GF(p) unit: add, sub, Montgomery mult and binary-
//          inversion divide behind a start/done handshake.
//          Optional macro GFAU_OPERAND_CHECK_EN rejects operands >= prime.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module gfau_param
  import gfau_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(4 * WIDTH + 4)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             start,
  input  logic [1:0]       op_sel,
  input  logic [WIDTH-1:0] in_0,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] prime,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam logic [CNT_W-1:0] c_mul_steps = CNT_W'(WIDTH);
  // DIV cycles are counted so that accept-to-done never exceeds the limit
  localparam logic [CNT_W-1:0] c_div_last  = CNT_W'(timeout_limit(WIDTH) - 2);

  state_t             r_state;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_a, r_b, r_p;
  logic [WIDTH+1:0]   r_m;
  logic [WIDTH-1:0]   r_u, r_v, r_x1, r_x2;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_bad;

  logic               w_bad_opnd;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_add, w_sub;
  logic [WIDTH+1:0]   w_t0, w_t1, w_m_next, w_m_fix;
  logic [WIDTH-1:0]   w_x1_half, w_x2_half, w_x1_sub, w_x2_sub;
  logic               w_div_end, w_div_err;
  logic [WIDTH-1:0]   w_div_res;

`ifdef GFAU_OPERAND_CHECK_EN
  assign w_bad_opnd = (in_0 >= prime) || (in_1 >= prime);
`else
  assign w_bad_opnd = 1'b0;
`endif

  assign w_sum = {1'b0, r_a} + {1'b0, r_b};
  assign w_add = WIDTH'((w_sum >= {1'b0, r_p}) ? (w_sum - {1'b0, r_p}) : w_sum);
  assign w_sub = WIDTH'((r_a >= r_b) ? ({1'b0, r_a} - {1'b0, r_b})
                                     : ({1'b0, r_a} - {1'b0, r_b} + {1'b0, r_p}));

  // One Montgomery bit step; r_a is shifted so bit 0 is always the current a[i]
  assign w_t0     = r_m + (r_a[0] ? {2'b00, r_b} : {(WIDTH+2){1'b0}});
  assign w_t1     = w_t0[0] ? (w_t0 + {2'b00, r_p}) : w_t0;
  assign w_m_next = w_t1 >> 1;
  assign w_m_fix  = (r_m >= {2'b00, r_p}) ? (r_m - {2'b00, r_p}) : r_m;

  gfau_half_mod #(.WIDTH(WIDTH)) u_half_x1 (.x(r_x1), .p(r_p), .y(w_x1_half));
  gfau_half_mod #(.WIDTH(WIDTH)) u_half_x2 (.x(r_x2), .p(r_p), .y(w_x2_half));

  assign w_x1_sub = WIDTH'((r_x1 >= r_x2) ? ({1'b0, r_x1} - {1'b0, r_x2})
                                          : ({1'b0, r_x1} - {1'b0, r_x2} + {1'b0, r_p}));
  assign w_x2_sub = WIDTH'((r_x2 >= r_x1) ? ({1'b0, r_x2} - {1'b0, r_x1})
                                          : ({1'b0, r_x2} - {1'b0, r_x1} + {1'b0, r_p}));

  assign w_div_end = (r_u == '0) || (r_u == WIDTH'(1)) || (r_v == WIDTH'(1)) ||
                     (r_cnt == c_div_last);

  // u==0 only arises from b==0 (or a non-prime p); the last branch is the timeout
  always_comb begin
    w_div_err = 1'b0;
    w_div_res = '0;
    if (r_u == '0)              w_div_err = 1'b1;
    else if (r_u == WIDTH'(1))  w_div_res = r_x1;
    else if (r_v == WIDTH'(1))  w_div_res = r_x2;
    else                        w_div_err = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_p     <= '0;
      r_m     <= '0;
      r_u     <= '0;
      r_v     <= '0;
      r_x1    <= '0;
      r_x2    <= '0;
      r_cnt   <= '0;
      r_bad   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op  <= op_sel;
            r_a   <= in_0;
            r_b   <= in_1;
            r_p   <= prime;
            r_m   <= '0;
            r_u   <= in_1;
            r_v   <= prime;
            r_x1  <= in_0;
            r_x2  <= '0;
            r_cnt <= '0;
            r_bad <= w_bad_opnd;
            busy  <= 1'b1;
            if (w_bad_opnd || op_sel == OP_ADD || op_sel == OP_SUB) r_state <= S_ADDSUB;
            else if (op_sel == OP_MUL)                              r_state <= S_MULT;
            else                                                    r_state <= S_DIV;
          end
        end
        S_ADDSUB: begin
          err     <= r_bad;
          result  <= r_bad ? '0 : ((r_op == OP_SUB) ? w_sub : w_add);
          busy    <= 1'b0;
          done    <= 1'b1;
          r_state <= S_FIN;
        end
        S_MULT: begin
          if (r_cnt == c_mul_steps) begin
            r_state <= S_MFIX;
          end else begin
            r_m   <= w_m_next;
            r_a   <= r_a >> 1;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_MFIX: begin
          result  <= WIDTH'(w_m_fix);
          err     <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b1;
          r_state <= S_FIN;
        end
        S_DIV: begin
          if (w_div_end) begin
            result  <= w_div_res;
            err     <= w_div_err;
            busy    <= 1'b0;
            done    <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (!r_u[0]) begin
              r_u  <= r_u >> 1;
              r_x1 <= w_x1_half;
            end else if (!r_v[0]) begin
              r_v  <= r_v >> 1;
              r_x2 <= w_x2_half;
            end else if (r_u >= r_v) begin
              r_u  <= r_u - r_v;
              r_x1 <= w_x1_sub;
            end else begin
              r_v  <= r_v - r_u;
              r_x2 <= w_x2_sub;
            end
          end
        end
        S_FIN: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gfau_param.sv
//==============================================================================
// Module : tb_gfau_param
// Brief  : Scoreboard bench for gfau_param at WIDTH=8, prime=251.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_gfau_param;

  localparam int W = 8;
  localparam logic [1:0] T_ADD = 2'd0;
  localparam logic [1:0] T_SUB = 2'd1;
  localparam logic [1:0] T_MUL = 2'd2;
  localparam logic [1:0] T_DIV = 2'd3;

  logic         clk    = 1'b0;
  logic         rst    = 1'b1;
  logic         start  = 1'b0;
  logic [1:0]   op_sel = 2'd0;
  logic [W-1:0] in_0   = '0;
  logic [W-1:0] in_1   = '0;
  logic [W-1:0] prime  = 8'd251;
  logic         busy, done, err;
  logic [W-1:0] result;

  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string        name;
    logic [W-1:0] res;
    logic         e;
    logic         chk_res;
    int           t0;
    int           lat;   // 0 = variable latency, bounded 2..36
  } exp_t;

  exp_t sb[$];

  gfau_param #(.WIDTH(W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .start (start),
    .op_sel(op_sel),
    .in_0  (in_0),
    .in_1  (in_1),
    .prime (prime),
    .busy  (busy),
    .done  (done),
    .result(result),
    .err   (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t x;
    int   lat;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: got done=1 result=%0d, expected no done", result);
        end else begin
          x   = sb.pop_front();
          lat = cyc - x.t0;
          check({x.name, "_err"}, 32'(err), 32'(x.e));
          if (x.chk_res) check({x.name, "_result"}, 32'(result), 32'(x.res));
          check({x.name, "_busy_low"}, 32'(busy), 32'd0);
          if (x.lat > 0) check({x.name, "_latency"}, lat, x.lat);
          else begin
            n_vec++;
            if (lat < 2 || lat > 36) begin
              n_err++;
              $display("FAIL %s_latency: got %0d, expected 2..36", x.name, lat);
            end
          end
        end
      end
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int t0);
    @(negedge clk);
    start  = 1'b1;
    op_sel = op;
    in_0   = a;
    in_1   = b;
    t0     = cyc;
    @(negedge clk);
    start  = 1'b0;
    in_0   = W'($urandom);
    in_1   = W'($urandom);
    op_sel = 2'($urandom);
  endtask

  task automatic issue(input string name, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] res, input logic e,
                       input logic cr, input int lat);
    int   t0;
    exp_t x;
    drive(op, a, b, t0);
    x.name = name; x.res = res; x.e = e; x.chk_res = cr; x.t0 = t0; x.lat = lat;
    sb.push_back(x);
    check({name, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input string name);
    for (int k = 0; k < 60; k++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_timeout: got no done, expected done within 60 cycles", name);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    fork monitor(); join_none

    repeat (3) @(negedge clk);
    check("rst_busy",   32'(busy),   32'd0);
    check("rst_done",   32'(done),   32'd0);
    check("rst_err",    32'(err),    32'd0);
    check("rst_result", 32'(result), 32'd0);
    rst = 1'b0;

    issue("add_200_100", T_ADD, 8'd200, 8'd100, 8'd49,  1'b0, 1'b1, 2);  wait_done("add_200_100");
    issue("add_1_250",   T_ADD, 8'd1,   8'd250, 8'd0,   1'b0, 1'b1, 2);  wait_done("add_1_250");
    issue("sub_10_20",   T_SUB, 8'd10,  8'd20,  8'd241, 1'b0, 1'b1, 2);  wait_done("sub_10_20");
    issue("sub_20_20",   T_SUB, 8'd20,  8'd20,  8'd0,   1'b0, 1'b1, 2);  wait_done("sub_20_20");
    issue("sub_0_250",   T_SUB, 8'd0,   8'd250, 8'd1,   1'b0, 1'b1, 2);  wait_done("sub_0_250");
    issue("mul_5_7",     T_MUL, 8'd5,   8'd7,   8'd7,   1'b0, 1'b1, 11); wait_done("mul_5_7");
    issue("mul_250_250", T_MUL, 8'd250, 8'd250, 8'd201, 1'b0, 1'b1, 11); wait_done("mul_250_250");
    issue("mul_1_1",     T_MUL, 8'd1,   8'd1,   8'd201, 1'b0, 1'b1, 11); wait_done("mul_1_1");
    issue("div_10_5",    T_DIV, 8'd10,  8'd5,   8'd2,   1'b0, 1'b1, 0);  wait_done("div_10_5");
    issue("div_1_2",     T_DIV, 8'd1,   8'd2,   8'd126, 1'b0, 1'b1, 0);  wait_done("div_1_2");
    issue("div_200_3",   T_DIV, 8'd200, 8'd3,   8'd234, 1'b0, 1'b1, 0);  wait_done("div_200_3");
    issue("div_123_1",   T_DIV, 8'd123, 8'd1,   8'd123, 1'b0, 1'b1, 2);  wait_done("div_123_1");
    issue("div_7_0",     T_DIV, 8'd7,   8'd0,   8'd0,   1'b1, 1'b1, 2);  wait_done("div_7_0");

    // start held high while busy and across the done cycle must not be accepted
    issue("mul_busy", T_MUL, 8'd5, 8'd7, 8'd7, 1'b0, 1'b1, 11);
    start = 1'b1; op_sel = T_ADD; in_0 = 8'd1; in_1 = 8'd1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
    @(negedge clk);
    start = 1'b0;
    wait_done("mul_busy");
    repeat (15) @(negedge clk);
    check("hold_result", 32'(result), 32'd7);
    check("hold_err",    32'(err),    32'd0);
    check("hold_busy",   32'(busy),   32'd0);

    // reset in the middle of a multiply
    drive(T_MUL, 8'd5, 8'd7, t0);
    @(posedge clk); @(posedge clk); @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy",   32'(busy),   32'd0);
    check("midrst_done",   32'(done),   32'd0);
    check("midrst_err",    32'(err),    32'd0);
    check("midrst_result", 32'(result), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    issue("add_after_rst", T_ADD, 8'd200, 8'd100, 8'd49, 1'b0, 1'b1, 2); wait_done("add_after_rst");

`ifdef GFAU_OPERAND_CHECK_EN
    issue("opnd_chk",   T_ADD, 8'd251, 8'd1, 8'd0, 1'b1, 1'b1, 2); wait_done("opnd_chk");
`else
    issue("opnd_nochk", T_ADD, 8'd251, 8'd1, 8'd0, 1'b0, 1'b0, 2); wait_done("opnd_nochk");
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
